// File: rtl/reg_file_sb_pkg.sv
// Shared constants, FSM state type and address helper for the scoreboarded register file.
package reg_file_sb_pkg;

    localparam int RF_DATA_W = 16;
    localparam int RF_DEPTH  = 8;
    localparam int RF_ADDR_W = $clog2(RF_DEPTH);

    typedef enum logic {
        SCRUB = 1'b0,
        READY = 1'b1
    } rf_state_e;

    // Addresses at or beyond depth exist only when DEPTH is not a power of two.
    function automatic logic addr_valid(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/reg_file_sb_if.sv
// Decode/writeback-facing bus of the register file: two read ports, writeback and issue strobes.
interface reg_file_sb_if
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W
) ();

    logic              init_done;
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_addr;

    modport master (
        input  init_done,
        output rd_addr1, rd_addr2,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2,
        output wr_en, wr_addr, wr_data,
        output issue_en, issue_addr
    );

    modport slave (
        output init_done,
        input  rd_addr1, rd_addr2,
        output rd_data1, rd_data2, rd_busy1, rd_busy2,
        input  wr_en, wr_addr, wr_data,
        input  issue_en, issue_addr
    );

endinterface

// File: rtl/reg_file_sb_rf_read_port.sv
// One read port: storage/busy mux, same-cycle write and issue bypass, zero-register and range masking.
module rf_read_port
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic              ready_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] mem_i [DEPTH],
    input  logic [DEPTH-1:0]  busy_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              issue_en_i,
    input  logic [ADDR_W-1:0] issue_addr_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_busy_o
);

    logic visible;

    assign visible = ready_i
                  && addr_valid(32'(rd_addr_i), 32'(DEPTH))
                  && !((ZERO_REG != 0) && (rd_addr_i == '0));

    // Strobes arrive pre-qualified, so masked addresses never match here.
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (visible) begin
            rd_data_o = mem_i[rd_addr_i];
            rd_busy_o = busy_i[rd_addr_i];
            if ((BYPASS != 0) && wr_en_i && (wr_addr_i == rd_addr_i)) begin
                rd_data_o = wr_data_i;
                rd_busy_o = 1'b0;
            end
            if ((BYPASS != 0) && issue_en_i && (issue_addr_i == rd_addr_i)) begin
                rd_busy_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with per-register busy scoreboard; zeroes every entry after reset before accepting traffic.
module reg_file_sb
    import reg_file_sb_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int DEPTH    = RF_DEPTH,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 0,
    parameter int BYPASS   = 1
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_sb_if.slave bus
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    rf_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic ready;
    logic scrub_we;
    logic wr_ok;
    logic issue_ok;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SCRUB;
            cnt_q   <= '0;
            busy_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            SCRUB: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_IDX) begin
                    state_d = READY;
                end
            end
            READY: ;
            default: state_d = SCRUB;
        endcase
    end

    always_comb begin
        ready    = (state_q == READY);
        scrub_we = (state_q == SCRUB) && !rst;
        wr_ok    = ready && bus.wr_en
                && addr_valid(32'(bus.wr_addr), 32'(DEPTH))
                && !((ZERO_REG != 0) && (bus.wr_addr == '0));
        issue_ok = ready && bus.issue_en
                && addr_valid(32'(bus.issue_addr), 32'(DEPTH))
                && !((ZERO_REG != 0) && (bus.issue_addr == '0));
    end

    // Issue is applied after the write so a coincident new producer keeps the entry busy.
    always_comb begin
        busy_d = busy_q;
        if (wr_ok) begin
            busy_d[bus.wr_addr] = 1'b0;
        end
        if (issue_ok) begin
            busy_d[bus.issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (scrub_we) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_ok) begin
            mem_q[bus.wr_addr] <= bus.wr_data;
        end
    end

    assign bus.init_done = ready;

    logic [DATA_W-1:0] rd_data1, rd_data2;
    logic              rd_busy1, rd_busy2;

    rf_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd1 (
        .ready_i      (ready),
        .rd_addr_i    (bus.rd_addr1),
        .mem_i        (mem_q),
        .busy_i       (busy_q),
        .wr_en_i      (wr_ok),
        .wr_addr_i    (bus.wr_addr),
        .wr_data_i    (bus.wr_data),
        .issue_en_i   (issue_ok),
        .issue_addr_i (bus.issue_addr),
        .rd_data_o    (rd_data1),
        .rd_busy_o    (rd_busy1)
    );

    rf_read_port #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (BYPASS)
    ) u_rd2 (
        .ready_i      (ready),
        .rd_addr_i    (bus.rd_addr2),
        .mem_i        (mem_q),
        .busy_i       (busy_q),
        .wr_en_i      (wr_ok),
        .wr_addr_i    (bus.wr_addr),
        .wr_data_i    (bus.wr_data),
        .issue_en_i   (issue_ok),
        .issue_addr_i (bus.issue_addr),
        .rd_data_o    (rd_data2),
        .rd_busy_o    (rd_busy2)
    );

    assign bus.rd_data1 = rd_data1;
    assign bus.rd_data2 = rd_data2;
    assign bus.rd_busy1 = rd_busy1;
    assign bus.rd_busy2 = rd_busy2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized checks of reg_file_sb (ZERO_REG=1, BYPASS=1) against an array-based model.
module tb_reg_file_sb;

    localparam int DW  = 16;
    localparam int DEP = 8;
    localparam int AW  = 3;
    localparam int ZR  = 1;
    localparam int BP  = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    reg_file_sb_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    reg_file_sb #(
        .DATA_W   (DW),
        .DEPTH    (DEP),
        .ADDR_W   (AW),
        .ZERO_REG (ZR),
        .BYPASS   (BP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state as it stands after the most recent rising edge.
    logic [DW-1:0] m_mem [DEP];
    bit            m_busy [DEP];
    bit            m_ready = 1'b0;
    bit            m_valid = 1'b0;
    int            m_cnt   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW:0] model_read(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        bit            b;
        if (!m_ready || int'(a) >= DEP || (ZR != 0 && a == 0)) return '0;
        d = m_mem[a];
        b = m_busy[a];
        if (BP != 0 && bus.wr_en && bus.wr_addr == a) begin
            d = bus.wr_data;
            b = 1'b0;
        end
        if (BP != 0 && bus.issue_en && bus.issue_addr == a) b = 1'b1;
        return {b, d};
    endfunction

    // Inputs only change just after a rising edge, so at the falling edge they hold the
    // values the next rising edge will sample: compare first, then advance the model.
    initial begin
        logic [DW:0] e1, e2;
        forever begin
            @(negedge clk);
            if (m_valid) begin
                e1 = model_read(bus.rd_addr1);
                e2 = model_read(bus.rd_addr2);
                chk("init_done", 32'(bus.init_done), 32'(m_ready));
                chk("rd_data1", 32'(bus.rd_data1), 32'(e1[DW-1:0]));
                chk("rd_busy1", 32'(bus.rd_busy1), 32'(e1[DW]));
                chk("rd_data2", 32'(bus.rd_data2), 32'(e2[DW-1:0]));
                chk("rd_busy2", 32'(bus.rd_busy2), 32'(e2[DW]));
            end
            if (rst) begin
                m_valid = 1'b1;
                m_ready = 1'b0;
                m_cnt   = 0;
                for (int i = 0; i < DEP; i++) m_busy[i] = 1'b0;
            end else if (m_valid && !m_ready) begin
                m_mem[m_cnt] = '0;
                m_cnt++;
                if (m_cnt == DEP) m_ready = 1'b1;
            end else if (m_valid) begin
                if (bus.wr_en && !(ZR != 0 && bus.wr_addr == 0)) begin
                    m_mem[bus.wr_addr]  = bus.wr_data;
                    m_busy[bus.wr_addr] = 1'b0;
                end
                if (bus.issue_en && !(ZR != 0 && bus.issue_addr == 0))
                    m_busy[bus.issue_addr] = 1'b1;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en      = 1'b0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        bus.issue_en   = 1'b0;
        bus.issue_addr = '0;
    endtask

    task automatic scrub_wait(input string tag);
        for (int i = 0; i < DEP; i++) begin
            @(negedge clk);
            chk({tag, "_init_low"}, 32'(bus.init_done), 32'd0);
            tick();
        end
        #1;
        chk({tag, "_init_high"}, 32'(bus.init_done), 32'd1);
    endtask

    initial begin
        idle_inputs();
        bus.rd_addr1 = '0;
        bus.rd_addr2 = '0;

        // Reset for two edges; a write held through scrub must be dropped.
        rst         = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd4;
        bus.wr_data = 16'h5555;
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("scrub_rd_data", 32'(bus.rd_data1), 32'h0);
        scrub_wait("scrub");
        idle_inputs();
        tick();
        for (int i = 0; i < DEP; i++) begin
            bus.rd_addr1 = AW'(i);
            bus.rd_addr2 = AW'(DEP - 1 - i);
            #1;
            chk("post_scrub_data", 32'(bus.rd_data1), 32'h0);
            chk("post_scrub_busy", 32'(bus.rd_busy1), 32'h0);
            tick();
        end

        // Write reg3, bypassed in the same cycle, stored for the next.
        bus.wr_en    = 1'b1;
        bus.wr_addr  = 3'd3;
        bus.wr_data  = 16'hBEEF;
        bus.rd_addr2 = 3'd3;
        #1;
        chk("wr_bypass", 32'(bus.rd_data2), 32'hBEEF);
        tick();
        idle_inputs();
        bus.rd_addr1 = 3'd3;
        #1;
        chk("wr_then_read", 32'(bus.rd_data1), 32'hBEEF);
        tick();

        // Issue reg5, then write it.
        bus.issue_en   = 1'b1;
        bus.issue_addr = 3'd5;
        tick();
        idle_inputs();
        bus.rd_addr1 = 3'd5;
        #1;
        chk("issue_busy", 32'(bus.rd_busy1), 32'h1);
        bus.wr_en   = 1'b1;
        bus.wr_addr = 3'd5;
        bus.wr_data = 16'h1234;
        #1;
        chk("wr_clears_busy", 32'(bus.rd_busy1), 32'h0);
        chk("wr_bypass_5", 32'(bus.rd_data1), 32'h1234);
        tick();
        idle_inputs();

        // Simultaneous write and issue to reg2.
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 3'd2;
        bus.wr_data    = 16'h7777;
        bus.issue_en   = 1'b1;
        bus.issue_addr = 3'd2;
        tick();
        idle_inputs();
        bus.rd_addr1 = 3'd2;
        #1;
        chk("simul_data", 32'(bus.rd_data1), 32'h7777);
        chk("simul_busy", 32'(bus.rd_busy1), 32'h1);
        tick();

        // Zero register ignores writes and issues.
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 3'd0;
        bus.wr_data    = 16'hFFFF;
        bus.issue_en   = 1'b1;
        bus.issue_addr = 3'd0;
        bus.rd_addr1   = 3'd0;
        #1;
        chk("zero_data_same", 32'(bus.rd_data1), 32'h0);
        chk("zero_busy_same", 32'(bus.rd_busy1), 32'h0);
        tick();
        idle_inputs();
        #1;
        chk("zero_data_after", 32'(bus.rd_data1), 32'h0);
        chk("zero_busy_after", 32'(bus.rd_busy1), 32'h0);
        tick();

        // Reset mid-operation.
        bus.wr_en      = 1'b1;
        bus.wr_addr    = 3'd6;
        bus.wr_data    = 16'hAAAA;
        bus.issue_en   = 1'b1;
        bus.issue_addr = 3'd6;
        tick();
        idle_inputs();
        bus.rd_addr1 = 3'd6;
        #1;
        chk("r6_data", 32'(bus.rd_data1), 32'hAAAA);
        chk("r6_busy", 32'(bus.rd_busy1), 32'h1);
        rst = 1'b1;
        tick();
        chk("rst_busy_clear", 32'(bus.rd_busy1), 32'h0);
        chk("rst_init_low", 32'(bus.init_done), 32'h0);
        rst = 1'b0;
        scrub_wait("rescrub");
        #1;
        chk("rescrub_r6", 32'(bus.rd_data1), 32'h0);
        tick();

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rst            = ($urandom_range(0, 299) == 0);
            bus.wr_en      = 1'($urandom_range(0, 1));
            bus.wr_addr    = AW'($urandom_range(0, DEP - 1));
            bus.wr_data    = DW'($urandom);
            bus.issue_en   = ($urandom_range(0, 2) == 0);
            bus.issue_addr = AW'($urandom_range(0, DEP - 1));
            bus.rd_addr1   = ($urandom_range(0, 3) == 0) ? bus.wr_addr : AW'($urandom_range(0, DEP - 1));
            bus.rd_addr2   = ($urandom_range(0, 3) == 0) ? bus.issue_addr : AW'($urandom_range(0, DEP - 1));
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_file_sb.md
# reg_file_sb

Parametrised, clocked register file with write-through read bypass, an optional hard-wired zero register, a per-register busy scoreboard and a post-reset scrub sequence. It is the successor to the 8×16 register file in the 16-bit custom processor. It sits between decode, which reads operands and issues destinations, and writeback, which writes results. It lets the pipeline detect pending producers without a separate hazard table.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- DEPTH, 8, number of registers (≥2)
- ADDR_W, $clog2(DEPTH), address width
- ZERO_REG, 0, 1 = register 0 always reads 0; writes and issues to it are ignored
- BYPASS, 1, 1 = same-cycle write data is forwarded to the read ports

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, synchronous, active-high
- init_done  out  1  high once the scrub has completed
- rd_addr1 / rd_addr2  in  ADDR_W  read addresses
- rd_data1 / rd_data2  out  DATA_W  combinational read data
- rd_busy1 / rd_busy2  out  1  combinational: the addressed register has a pending producer
- wr_en  in  1  writeback strobe
- wr_addr  in  ADDR_W  writeback destination
- wr_data  in  DATA_W  writeback data
- issue_en  in  1  marks issue_addr busy (new producer issued)
- issue_addr  in  ADDR_W  destination being issued

## Operation
- Two-state FSM: SCRUB, then READY.
- SCRUB:
  - Entered on any cycle with rst=1. The scrub counter is set to 0 and every busy bit is cleared.
  - After rst deasserts, each cycle writes 0 to reg[cnt] and increments cnt.
  - The FSM moves to READY after writing DEPTH-1.
  - wr_en and issue_en are ignored. rd_data* read 0 and rd_busy* read 0.
- READY:
  - wr_en=1 writes wr_data to reg[wr_addr] and clears busy[wr_addr].
  - issue_en=1 sets busy[issue_addr].
- Simultaneous wr_en and issue_en to the same address: the data is written and busy ends at 1 (the new producer wins).
- Read bypass (BYPASS=1):
  - If wr_en is high and rd_addrN==wr_addr, rd_dataN=wr_data and rd_busyN=0.
  - If issue_en is also high with issue_addr==rd_addrN, rd_busyN=1.
- With BYPASS=0, reads return the stored value and the current busy bit only.
- ZERO_REG=1: address 0 reads data 0 and busy 0 at all times; writes and issues to address 0 have no effect. The scrub still covers address 0.
- Out-of-range addresses (DEPTH not a power of two): reads return 0 and busy 0; writes and issues are dropped.

## Timing
- Reset values: init_done=0, FSM=SCRUB, cnt=0, busy=all 0. rd_data* and rd_busy* read 0 while in SCRUB.
- If rst is high at edge T0 and low afterwards, init_done rises after edge T0+DEPTH. That is, DEPTH cycles of scrub follow reset release.
- Reset asserted mid-scrub or mid-operation: the FSM returns to SCRUB and the count restarts at 0. Register contents are undefined until the rescrub completes.
- Write latency: a write at edge T is visible to a non-bypassed read in the cycle after T. With BYPASS=1 it is visible combinationally in the same cycle.
- Busy latency: issue at edge T shows rd_busy=1 from the cycle after T, or in the same cycle via the issue bypass.
- No backpressure: every strobe in READY is accepted in the cycle it is presented.

## Structure
- The shared processor package holds:
  - the default DATA_W, DEPTH and ADDR_W constants;
  - the SCRUB/READY state enum;
  - a helper for the address-valid check.
- A single sub-module, rf_read_port, implements the read mux with bypass, the zero-register mask and the busy-bit mux. It is instantiated twice.
- Storage, the scoreboard vector, the scrub counter and the FSM stay in the top module.

## Test plan
- **Reset and scrub:** rst for 2 cycles, then release with DEPTH=8.
  - init_done=0 for 8 cycles, then 1.
  - All 8 registers read 0x0000; all busy bits 0.
  - A wr_en issued during scrub is dropped.
- **Write then read:**
  - wr reg3=0xBEEF; the next cycle rd_addr1=3 returns 0xBEEF.
  - In the same cycle as the write, rd_addr2=3 returns 0xBEEF with BYPASS=1, or the old 0x0000 with BYPASS=0.
- **Scoreboard, basic:**
  - issue reg5 → rd_busy=1 on the following cycle.
  - wr reg5=0x1234 → rd_busy=0 and data=0x1234 combinationally in that cycle.
- **Scoreboard, simultaneous events:** issue and wr to reg2 in the same cycle → data updated, busy remains 1.
- **ZERO_REG=1:** wr reg0=0xFFFF and issue reg0 → reg0 reads 0x0000, busy 0.
- **Reset mid-operation:** reg6=0xAAAA with busy set, then assert rst.
  - busy clears immediately.
  - After the scrub, reg6 reads 0x0000 and init_done reasserts DEPTH cycles after release.
